// File: rtl/rf_operand_fetch_if.sv
// Bundle of the operand-fetch stage's issue, register-file, writeback and execute signals.
// The slave modport is the fetch stage; the master modport is whatever surrounds it.
interface rf_operand_fetch_if;
  logic        i_iss_valid;
  logic        o_iss_ready;
  logic [4:0]  i_iss_rs1;
  logic [4:0]  i_iss_rs2;
  logic [4:0]  i_iss_rd;
  logic        i_iss_rd_en;

  logic [4:0]  o_rf_addr1;
  logic [4:0]  o_rf_addr2;
  logic [31:0] i_rf_data1;
  logic [31:0] i_rf_data2;

  logic        i_wb_valid;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;

  logic        o_ex_valid;
  logic        i_ex_ready;
  logic [31:0] o_ex_op1;
  logic [31:0] o_ex_op2;
  logic [4:0]  o_ex_rd;
  logic        o_ex_rd_en;

  logic [31:0] o_busy;

  modport slave (
    input  i_iss_valid, i_iss_rs1, i_iss_rs2, i_iss_rd, i_iss_rd_en,
    input  i_rf_data1, i_rf_data2,
    input  i_wb_valid, i_wb_addr, i_wb_data,
    input  i_ex_ready,
    output o_iss_ready, o_rf_addr1, o_rf_addr2,
    output o_ex_valid, o_ex_op1, o_ex_op2, o_ex_rd, o_ex_rd_en,
    output o_busy
  );

  modport master (
    output i_iss_valid, i_iss_rs1, i_iss_rs2, i_iss_rd, i_iss_rd_en,
    output i_rf_data1, i_rf_data2,
    output i_wb_valid, i_wb_addr, i_wb_data,
    output i_ex_ready,
    input  o_iss_ready, o_rf_addr1, o_rf_addr2,
    input  o_ex_valid, o_ex_op1, o_ex_op2, o_ex_rd, o_ex_rd_en,
    input  o_busy
  );
endinterface

// File: rtl/rf_operand_fetch.sv
// Operand fetch with a busy-bit scoreboard: captures an issue, waits for both sources,
// forwards a same-cycle writeback over the register file, and hands the bundle to execute.
module rf_operand_fetch #(
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rf_operand_fetch_if.slave    bus
);

  localparam bit ZeroEn = (ZERO_REG != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t      state_q;
  logic        iss_ready_q;
  logic        ex_valid_q;
  logic [31:0] ex_op_q [2];
  logic [4:0]  ex_rd_q;
  logic        ex_rd_en_q;
  logic [4:0]  rs_q [2];
  logic [4:0]  rd_q;
  logic        rd_en_q;
  logic [31:0] busy_q;
  logic [31:0] busy_d;

  logic [31:0] rf_data [2];
  logic [1:0]  src_zero;
  logic [1:0]  src_fwd;
  logic [1:0]  src_ready;
  logic [31:0] op_d [2];
  logic        both_ready;
  logic        fire_eval;

  assign rf_data[0] = bus.i_rf_data1;
  assign rf_data[1] = bus.i_rf_data2;

  // Each source: hardwired zero first, then the in-flight writeback, then the RF read.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_zero[gi]  = ZeroEn && (rs_q[gi] == 5'd0);
    assign src_fwd[gi]   = bus.i_wb_valid && (bus.i_wb_addr == rs_q[gi]);
    assign src_ready[gi] = src_zero[gi] || !busy_q[rs_q[gi]] || src_fwd[gi];
    assign op_d[gi]      = src_zero[gi] ? 32'h0 :
                           src_fwd[gi]  ? bus.i_wb_data : rf_data[gi];
  end

  assign both_ready = &src_ready;
  assign fire_eval  = (state_q == EVAL) && both_ready;

  // Writeback clears before the issuing instruction sets, so a same-bit collision stays busy.
  always_comb begin
    busy_d = busy_q;
    if (bus.i_wb_valid) begin
      busy_d[bus.i_wb_addr] = 1'b0;
    end
    if (fire_eval && rd_en_q && !(ZeroEn && (rd_q == 5'd0))) begin
      busy_d[rd_q] = 1'b1;
    end
    if (ZeroEn) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      iss_ready_q <= 1'b1;
      ex_valid_q  <= 1'b0;
      ex_op_q[0]  <= 32'h0;
      ex_op_q[1]  <= 32'h0;
      ex_rd_q     <= 5'd0;
      ex_rd_en_q  <= 1'b0;
      rs_q[0]     <= 5'd0;
      rs_q[1]     <= 5'd0;
      rd_q        <= 5'd0;
      rd_en_q     <= 1'b0;
      busy_q      <= 32'h0;
    end else begin
      busy_q <= busy_d;
      case (state_q)
        IDLE: begin
          if (bus.i_iss_valid) begin
            rs_q[0]     <= bus.i_iss_rs1;
            rs_q[1]     <= bus.i_iss_rs2;
            rd_q        <= bus.i_iss_rd;
            rd_en_q     <= bus.i_iss_rd_en;
            iss_ready_q <= 1'b0;
            state_q     <= EVAL;
          end
        end
        EVAL: begin
          if (both_ready) begin
            ex_op_q[0] <= op_d[0];
            ex_op_q[1] <= op_d[1];
            ex_rd_q    <= rd_q;
            ex_rd_en_q <= rd_en_q;
            ex_valid_q <= 1'b1;
            state_q    <= OUT;
          end
        end
        OUT: begin
          if (bus.i_ex_ready) begin
            ex_valid_q  <= 1'b0;
            iss_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          ex_valid_q  <= 1'b0;
          iss_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_iss_ready = iss_ready_q;
  assign bus.o_rf_addr1  = rs_q[0];
  assign bus.o_rf_addr2  = rs_q[1];
  assign bus.o_ex_valid  = ex_valid_q;
  assign bus.o_ex_op1    = ex_op_q[0];
  assign bus.o_ex_op2    = ex_op_q[1];
  assign bus.o_ex_rd     = ex_rd_q;
  assign bus.o_ex_rd_en  = ex_rd_en_q;
  assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Directed bench for rf_operand_fetch: a behavioural register file is attached to the
// read/write ports and every expected value below is worked out by hand.
module tb_rf_operand_fetch;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  rf_operand_fetch_if bus ();

  rf_operand_fetch #(.ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: two combinational reads, written by the writeback port.
  logic [31:0] rf_mem [32];
  assign bus.i_rf_data1 = rf_mem[bus.o_rf_addr1];
  assign bus.i_rf_data2 = rf_mem[bus.o_rf_addr2];
  always @(posedge clk) begin
    if (bus.i_wb_valid) rf_mem[bus.i_wb_addr] <= bus.i_wb_data;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.i_wb_valid = v;
    bus.i_wb_addr  = a;
    bus.i_wb_data  = d;
  endtask

  // Presents an issue for one cycle; returns at the negedge where the DUT sits in EVAL.
  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rd_en);
    check_val("iss_ready_before_issue", 32'(bus.o_iss_ready), 32'h1);
    bus.i_iss_valid = 1'b1;
    bus.i_iss_rs1   = rs1;
    bus.i_iss_rs2   = rs2;
    bus.i_iss_rd    = rd;
    bus.i_iss_rd_en = rd_en;
    tick();
    bus.i_iss_valid = 1'b0;
    $display("txn issue rs1=%0d rs2=%0d rd=%0d rd_en=%0d", rs1, rs2, rd, rd_en);
  endtask

  task automatic retire();
    bus.i_ex_ready = 1'b1;
    tick();
    bus.i_ex_ready = 1'b0;
    check_val("ex_valid_after_retire", 32'(bus.o_ex_valid), 32'h0);
    check_val("iss_ready_after_retire", 32'(bus.o_iss_ready), 32'h1);
  endtask

  // Marks register rd busy through a full issue/retire with zero sources.
  task automatic make_busy(input logic [4:0] rd);
    issue(5'd0, 5'd0, rd, 1'b1);
    tick();
    check_val("make_busy_ex_valid", 32'(bus.o_ex_valid), 32'h1);
    retire();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
    rst_n = 1'b0;
    bus.i_iss_valid = 1'b0;
    bus.i_iss_rs1   = 5'd0;
    bus.i_iss_rs2   = 5'd0;
    bus.i_iss_rd    = 5'd0;
    bus.i_iss_rd_en = 1'b0;
    bus.i_ex_ready  = 1'b0;
    set_wb(1'b0, 5'd0, 32'h0);

    // Reset state
    tick();
    tick();
    check_val("reset_busy", bus.o_busy, 32'h0);
    check_val("reset_ex_valid", 32'(bus.o_ex_valid), 32'h0);
    check_val("reset_rf_addr1", 32'(bus.o_rf_addr1), 32'h0);
    rst_n = 1'b1;
    tick();
    check_val("post_reset_iss_ready", 32'(bus.o_iss_ready), 32'h1);

    // Preload RF through writeback (x0 gets garbage the DUT must ignore)
    set_wb(1'b1, 5'd1, 32'd5);           tick();
    set_wb(1'b1, 5'd2, 32'd7);           tick();
    set_wb(1'b1, 5'd4, 32'd1);           tick();
    set_wb(1'b1, 5'd0, 32'h1234_5678);   tick();
    set_wb(1'b0, 5'd0, 32'h0);
    $display("txn preload x1=5 x2=7 x4=1 x0=0x12345678");

    // Basic fetch, then hold execute off for three cycles
    issue(5'd1, 5'd2, 5'd3, 1'b1);
    check_val("basic_ex_valid_1cyc", 32'(bus.o_ex_valid), 32'h0);
    check_val("basic_iss_ready_eval", 32'(bus.o_iss_ready), 32'h0);
    check_val("basic_rf_addr2", 32'(bus.o_rf_addr2), 32'd2);
    tick();
    check_val("basic_ex_valid", 32'(bus.o_ex_valid), 32'h1);
    check_val("basic_op1", bus.o_ex_op1, 32'd5);
    check_val("basic_op2", bus.o_ex_op2, 32'd7);
    check_val("basic_rd", 32'(bus.o_ex_rd), 32'd3);
    check_val("basic_rd_en", 32'(bus.o_ex_rd_en), 32'h1);
    check_val("basic_busy", bus.o_busy, 32'h0000_0008);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("hold_ex_valid", 32'(bus.o_ex_valid), 32'h1);
      check_val("hold_op1", bus.o_ex_op1, 32'd5);
      check_val("hold_op2", bus.o_ex_op2, 32'd7);
      check_val("hold_rd", 32'(bus.o_ex_rd), 32'd3);
      check_val("hold_iss_ready", 32'(bus.o_iss_ready), 32'h0);
    end
    retire();

    // Stall on busy x3, then forward the writeback; x0 reads as zero
    issue(5'd3, 5'd0, 5'd6, 1'b0);
    check_val("stall_ex_valid_0", 32'(bus.o_ex_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("stall_ex_valid", 32'(bus.o_ex_valid), 32'h0);
    end
    set_wb(1'b1, 5'd3, 32'hDEAD_BEEF);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    check_val("stall_release_valid", 32'(bus.o_ex_valid), 32'h1);
    check_val("stall_op1_fwd", bus.o_ex_op1, 32'hDEAD_BEEF);
    check_val("stall_op2_zero", bus.o_ex_op2, 32'h0);
    check_val("stall_busy_clear", bus.o_busy, 32'h0);
    retire();

    // Forward beats the stale RF value for a non-busy source
    issue(5'd4, 5'd1, 5'd7, 1'b0);
    set_wb(1'b1, 5'd4, 32'd9);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    check_val("fwd_op1", bus.o_ex_op1, 32'd9);
    check_val("fwd_op2", bus.o_ex_op2, 32'd5);
    check_val("fwd_busy", bus.o_busy, 32'h0);
    retire();

    // Self-dependency: x5 busy, rs1=rd=5; writeback clears and issue re-sets
    make_busy(5'd5);
    check_val("self_busy_pre", bus.o_busy, 32'h0000_0020);
    issue(5'd5, 5'd0, 5'd5, 1'b1);
    tick();
    check_val("self_stall", 32'(bus.o_ex_valid), 32'h0);
    set_wb(1'b1, 5'd5, 32'd11);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    check_val("self_ex_valid", 32'(bus.o_ex_valid), 32'h1);
    check_val("self_op1", bus.o_ex_op1, 32'd11);
    check_val("self_busy_set_wins", bus.o_busy, 32'h0000_0020);
    retire();

    // Clear x5, then a writeback in IDLE to a non-busy register is a no-op
    set_wb(1'b1, 5'd5, 32'd11); tick();
    set_wb(1'b1, 5'd9, 32'd0);  tick();
    set_wb(1'b0, 5'd0, 32'h0);
    check_val("idle_wb_clear", bus.o_busy, 32'h0);

    // Asynchronous reset in the middle of a stalled EVAL
    make_busy(5'd3);
    make_busy(5'd4);
    check_val("rst_busy_pre", bus.o_busy, 32'h0000_0018);
    issue(5'd3, 5'd0, 5'd8, 1'b1);
    check_val("rst_in_eval", 32'(bus.o_iss_ready), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_async_busy", bus.o_busy, 32'h0);
    check_val("rst_async_ex_valid", 32'(bus.o_ex_valid), 32'h0);
    check_val("rst_async_iss_ready", 32'(bus.o_iss_ready), 32'h1);
    check_val("rst_async_rf_addr1", 32'(bus.o_rf_addr1), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check_val("rst_release_iss_ready", 32'(bus.o_iss_ready), 32'h1);
    check_val("rst_release_ex_valid", 32'(bus.o_ex_valid), 32'h0);

    // Normal operation resumes after reset
    issue(5'd1, 5'd2, 5'd9, 1'b1);
    tick();
    check_val("post_rst_op1", bus.o_ex_op1, 32'd5);
    check_val("post_rst_op2", bus.o_ex_op2, 32'd7);
    check_val("post_rst_busy", bus.o_busy, 32'h0000_0200);
    retire();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
